io_port_unit: RTL and testbench
===============================

// Module: io_port_unit
// PURPOSE
//  Datapath I/O stage downstream of the multicycle control FSM.
//  - Consumes OutWrite (the "out" state) and the "in" state strobe (InRead).
//  - Buffers accumulator writes in an output FIFO and drains them to the external device with a valid/ready handshake.
//  - Captures words from the external input device and presents them as InData on the ACCSrc=01 input of the ACC mux.
// PARAMETERS
//  WIDTH        16  data word width (ACC, device buses)
//  OUT_DEPTH     4  output FIFO entries; power of two, >=2
//  SYNC_STAGES   2  synchroniser flops on dev_in_strobe; >=2
// PORTS
//  clk            in   1      system clock; all flops rise-edge
//  reset          in   1      asynchronous, active-low reset (0 = reset)
//  OutWrite       in   1      from control: push ACC into output FIFO this cycle
//  InRead         in   1      from control: "in" state; ACC takes InData this cycle
//  ACC            in   WIDTH  accumulator value to be output
//  InData         out  WIDTH  captured input word to ACC mux (ACCSrc=01)
//  in_available   out  1      unread word held in InData
//  dev_out_data   out  WIDTH  FIFO head word to device
//  dev_out_valid  out  1      FIFO non-empty
//  dev_out_ready  in   1      device accepts head word this cycle
//  dev_in_data    in   WIDTH  device input word; stable while strobe high
//  dev_in_strobe  in   1      device strobe; asynchronous to clk
//  out_full       out  1      FIFO holds OUT_DEPTH entries
//  out_overflow   out  1      sticky: an OutWrite was dropped
// BEHAVIOUR
//  Reset (reset=0, async)
//   - FIFO empty; rd/wr pointers, count, sync chain and edge flop all 0.
//   - Outputs: InData=0, in_available=0, dev_out_valid=0, dev_out_data=0, out_full=0, out_overflow=0.
//   - Entries in flight are discarded.
//  Output FIFO
//   - Circular buffer with log2(OUT_DEPTH)-bit pointers; pointers wrap modulo OUT_DEPTH.
//   - Count is log2(OUT_DEPTH)+1 bits wide.
//   - Push: OutWrite=1 and (not full, or pop in the same cycle). ACC is written at the edge.
//   - Pop: dev_out_valid & dev_out_ready; rd pointer advances at the edge.
//   - dev_out_data = mem[rd_ptr], registered-array read. It is stable while valid=1 and ready=0.
//   - Latency: word pushed at edge N is visible on dev_out_data/valid after edge N when the FIFO was empty.
//   - Push + pop in the same cycle: count unchanged, at any fill level including full.
//   - Push while full with no pop: word dropped, pointers unchanged, out_overflow<=1.
//   - out_overflow clears only on reset.
//   - Pop while empty is impossible because valid=0.
//  Input capture
//   - dev_in_strobe passes through SYNC_STAGES flops; a rising edge of the last stage is detected.
//   - On a detected edge, dev_in_data is registered into InData and in_available<=1.
//   - Strobe-to-InData latency: SYNC_STAGES+1 clk edges.
//   - InRead=1: in_available<=0 at the edge. ACC samples the current InData in that cycle.
//   - Capture + InRead in the same cycle: ACC gets the old word, InData takes the new word, in_available stays 1.
//   - Capture while in_available=1 and no read: newer word overwrites; no flag.
//   - InRead while in_available=0: ACC gets the stale InData; no state change.
//  Control contract
//   - OutWrite and InRead are single-cycle and mutually exclusive.
//   - The block never stalls control. Software polls out_full/in_available if needed.
// TESTING
//  T1: reset=0 mid-transfer (FIFO 3 deep, in_available=1) -> all outputs 0 immediately, without waiting for clk.
//  T2: dev_out_ready=0; OutWrite with ACC=0x0001..0x0004 -> out_full=1. 5th write 0x0005 -> dropped, out_overflow=1. Ready=1 drains 1,2,3,4 in order.
//  T3: full FIFO, OutWrite ACC=0xBEEF with ready=1 -> head popped, 0xBEEF accepted, out_full stays 1, no overflow.
//  T4: dev_in_data=0x1234, strobe pulse -> InData=0x1234, in_available=1 at edge SYNC_STAGES+1. InRead -> in_available=0.
//  T5: in_available=1 (0x1111); InRead coincides with capture of 0x2222 -> ACC gets 0x1111, InData=0x2222, in_available=1.
//  T6: 10 pushes/pops interleaved across pointer wrap (OUT_DEPTH=4) -> output sequence matches input, no loss.

Source files
------------

// File: rtl/io_port_unit.sv
// I/O stage: output FIFO toward the external device (valid/ready drain) and
// synchronised strobe capture of device input words for the ACC input mux.
module io_port_unit #(
  parameter int WIDTH       = 16,
  parameter int OUT_DEPTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             OutWrite,
  input  logic             InRead,
  input  logic [WIDTH-1:0] ACC,
  output logic [WIDTH-1:0] InData,
  output logic             in_available,
  output logic [WIDTH-1:0] dev_out_data,
  output logic             dev_out_valid,
  input  logic             dev_out_ready,
  input  logic [WIDTH-1:0] dev_in_data,
  input  logic             dev_in_strobe,
  output logic             out_full,
  output logic             out_overflow
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(OUT_DEPTH);

  logic [WIDTH-1:0]       mem_q [OUT_DEPTH];
  logic [WIDTH-1:0]       mem_d [OUT_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic [WIDTH-1:0]       in_data_q, in_data_d;
  logic                   avail_q, avail_d;

  logic push_s;
  logic pop_s;
  logic full_s;
  logic valid_s;
  logic capture_s;

  // Output FIFO next-state: push allowed when full only if the head leaves this cycle.
  always_comb begin
    full_s     = (count_q == FULL_COUNT);
    valid_s    = (count_q != {CW{1'b0}});
    pop_s      = valid_s && dev_out_ready;
    push_s     = OutWrite && (!full_s || pop_s);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = ACC;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (OutWrite && !push_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Input capture next-state: a fresh capture wins over a simultaneous read.
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], dev_in_strobe};
    edge_d    = sync_q[SYNC_STAGES-1];
    capture_s = sync_q[SYNC_STAGES-1] && !edge_q;
    in_data_d = in_data_q;
    avail_d   = avail_q;
    if (capture_s) begin
      in_data_d = dev_in_data;
      avail_d   = 1'b1;
    end else if (InRead) begin
      avail_d = 1'b0;
    end else begin
      avail_d = avail_q;
    end
  end

  // State registers; the array is cleared too so dev_out_data reads 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
      sync_q     <= {SYNC_STAGES{1'b0}};
      edge_q     <= 1'b0;
      in_data_q  <= {WIDTH{1'b0}};
      avail_q    <= 1'b0;
    end else begin
      for (int i = 0; i < OUT_DEPTH; i++) mem_q[i] <= mem_d[i];
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      sync_q     <= sync_d;
      edge_q     <= edge_d;
      in_data_q  <= in_data_d;
      avail_q    <= avail_d;
    end
  end

  assign dev_out_data  = mem_q[rd_ptr_q];
  assign dev_out_valid = valid_s;
  assign out_full      = full_s;
  assign out_overflow  = overflow_q;
  assign InData        = in_data_q;
  assign in_available  = avail_q;

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: FIFO fill/overflow/drain, full push+pop,
// async reset, strobe capture latency, capture/read collision, pointer wrap.
module tb_io_port_unit;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             OutWrite;
  logic             InRead;
  logic [WIDTH-1:0] ACC;
  logic [WIDTH-1:0] InData;
  logic             in_available;
  logic [WIDTH-1:0] dev_out_data;
  logic             dev_out_valid;
  logic             dev_out_ready;
  logic [WIDTH-1:0] dev_in_data;
  logic             dev_in_strobe;
  logic             out_full;
  logic             out_overflow;

  int checks   = 0;
  int failures = 0;

  io_port_unit #(.WIDTH(WIDTH), .OUT_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .OutWrite(OutWrite), .InRead(InRead), .ACC(ACC),
    .InData(InData), .in_available(in_available), .dev_out_data(dev_out_data),
    .dev_out_valid(dev_out_valid), .dev_out_ready(dev_out_ready),
    .dev_in_data(dev_in_data), .dev_in_strobe(dev_in_strobe),
    .out_full(out_full), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; OutWrite = 1'b0; InRead = 1'b0; ACC = 16'h0000;
    dev_out_ready = 1'b0; dev_in_data = 16'h0000; dev_in_strobe = 1'b0;
    tick(); tick();
    checks++;
    if ({InData, in_available, dev_out_data, dev_out_valid, out_full, out_overflow} !== 36'h0) begin
      failures++;
      $display("FAIL reset_state got InData=%h avail=%b data=%h valid=%b full=%b ovf=%b want all 0",
               InData, in_available, dev_out_data, dev_out_valid, out_full, out_overflow);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_overflow();
    dev_out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      OutWrite = 1'b1; ACC = 16'(i); tick();
    end
    checks++;
    if (out_full !== 1'b1 || out_overflow !== 1'b0 || dev_out_data !== 16'h0001) begin
      failures++;
      $display("FAIL fill4 got full=%b ovf=%b data=%h want 1 0 0001", out_full, out_overflow, dev_out_data);
    end
    ACC = 16'h0005; tick();
    OutWrite = 1'b0;
    checks++;
    if (out_overflow !== 1'b1 || out_full !== 1'b1 || dev_out_data !== 16'h0001) begin
      failures++;
      $display("FAIL overflow got ovf=%b full=%b data=%h want 1 1 0001", out_overflow, out_full, dev_out_data);
    end
    dev_out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if (dev_out_valid !== 1'b1 || dev_out_data !== 16'(i)) begin
        failures++;
        $display("FAIL drain%0d got valid=%b data=%h want 1 %h", i, dev_out_valid, dev_out_data, 16'(i));
      end
      tick();
    end
    checks++;
    if (dev_out_valid !== 1'b0 || out_overflow !== 1'b1) begin
      failures++;
      $display("FAIL drained got valid=%b ovf=%b want 0 1", dev_out_valid, out_overflow);
    end
    dev_out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      OutWrite = 1'b1; ACC = 16'h0700 + 16'(i); tick();
    end
    OutWrite = 1'b0;
    dev_in_data = 16'h00AA; dev_in_strobe = 1'b1;
    tick(); tick(); tick();
    dev_in_strobe = 1'b0;
    checks++;
    if (in_available !== 1'b1 || dev_out_data !== 16'h0700 || out_full !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset got avail=%b data=%h full=%b want 1 0700 0", in_available, dev_out_data, out_full);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({InData, in_available, dev_out_data, dev_out_valid, out_full, out_overflow} !== 36'h0) begin
      failures++;
      $display("FAIL async_reset got InData=%h avail=%b data=%h valid=%b full=%b ovf=%b want all 0",
               InData, in_available, dev_out_data, dev_out_valid, out_full, out_overflow);
    end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_push_pop();
    dev_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      OutWrite = 1'b1; ACC = 16'h00A0 + 16'(i); tick();
    end
    dev_out_ready = 1'b1; ACC = 16'hBEEF; tick();
    OutWrite = 1'b0; dev_out_ready = 1'b0;
    checks++;
    if (out_full !== 1'b1 || out_overflow !== 1'b0 || dev_out_data !== 16'h00A1) begin
      failures++;
      $display("FAIL full_push_pop got full=%b ovf=%b data=%h want 1 0 00a1", out_full, out_overflow, dev_out_data);
    end
    dev_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dev_out_data !== ((i == 3) ? 16'hBEEF : 16'h00A1 + 16'(i))) begin
        failures++;
        $display("FAIL full_drain%0d got %h want %h", i, dev_out_data,
                 (i == 3) ? 16'hBEEF : 16'h00A1 + 16'(i));
      end
      tick();
    end
    dev_out_ready = 1'b0;
  endtask

  task automatic test_capture();
    dev_in_data = 16'h1234; dev_in_strobe = 1'b1;
    tick();
    checks++;
    if (in_available !== 1'b0) begin
      failures++; $display("FAIL cap_edge1 got avail=%b want 0", in_available);
    end
    tick();
    checks++;
    if (in_available !== 1'b0) begin
      failures++; $display("FAIL cap_edge2 got avail=%b want 0", in_available);
    end
    tick();
    checks++;
    if (in_available !== 1'b1 || InData !== 16'h1234) begin
      failures++; $display("FAIL cap_edge3 got avail=%b InData=%h want 1 1234", in_available, InData);
    end
    dev_in_strobe = 1'b0; dev_in_data = 16'hFFFF;
    InRead = 1'b1; tick(); InRead = 1'b0;
    checks++;
    if (in_available !== 1'b0 || InData !== 16'h1234) begin
      failures++; $display("FAIL in_read got avail=%b InData=%h want 0 1234", in_available, InData);
    end
    InRead = 1'b1; tick(); InRead = 1'b0;
    checks++;
    if (in_available !== 1'b0 || InData !== 16'h1234) begin
      failures++; $display("FAIL stale_read got avail=%b InData=%h want 0 1234", in_available, InData);
    end
  endtask

  task automatic test_capture_read_collision();
    dev_in_data = 16'h1111; dev_in_strobe = 1'b1;
    tick(); tick(); tick();
    dev_in_strobe = 1'b0;
    tick(); tick(); tick();
    dev_in_data = 16'h2222; dev_in_strobe = 1'b1;
    tick(); tick();
    InRead = 1'b1;
    checks++;
    if (InData !== 16'h1111 || in_available !== 1'b1) begin
      failures++; $display("FAIL collide_old got InData=%h avail=%b want 1111 1", InData, in_available);
    end
    tick();
    InRead = 1'b0; dev_in_strobe = 1'b0;
    checks++;
    if (InData !== 16'h2222 || in_available !== 1'b1) begin
      failures++; $display("FAIL collide_new got InData=%h avail=%b want 2222 1", InData, in_available);
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] q[$];
    int popped = 0;
    logic do_pop;
    for (int i = 0; i < 24; i++) begin
      OutWrite      = (i < 10);
      ACC           = 16'h0C00 + 16'(i);
      dev_out_ready = (i >= 10) || (i % 3 != 0);
      do_pop        = (q.size() != 0) && dev_out_ready;
      checks++;
      if (dev_out_valid !== (q.size() != 0) || (q.size() != 0 && dev_out_data !== q[0])) begin
        failures++;
        $display("FAIL wrap%0d got valid=%b data=%h want valid=%b data=%h", i, dev_out_valid, dev_out_data,
                 q.size() != 0, (q.size() != 0) ? q[0] : 16'h0000);
      end
      tick();
      if (do_pop) begin
        void'(q.pop_front());
        popped++;
      end
      if (OutWrite) q.push_back(ACC);
    end
    OutWrite = 1'b0; dev_out_ready = 1'b0;
    checks++;
    if (popped != 10 || out_overflow !== 1'b0 || dev_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL wrap_total got popped=%0d ovf=%b valid=%b want 10 0 0", popped, out_overflow, dev_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_overflow();
    test_async_reset();
    test_full_push_pop();
    test_capture();
    test_capture_read_collision();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
